// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   General-purpose integer register file for the 32-bit datapath.
//   32 entries of DATA_WIDTH bits, two combinational read ports and one
//   synchronous write port. Entry 0 is hardwired to zero.
//
// Ports:
//   clk        - system clock; writes occur on its rising edge
//   reset      - asynchronous active-low reset; clears every entry
//   RegWrite   - write enable, sampled on rising clk
//   read_reg1  - address for read port 1
//   read_reg2  - address for read port 2
//   write_reg  - write address
//   write_data - write data
//   read_data1 - contents of entry read_reg1 (0 for address 0)
//   read_data2 - contents of entry read_reg2 (0 for address 0)
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic                  write_en_s;

    // Qualified write strobe: address 0 is never stored.
    always_comb begin
        write_en_s = 1'b0;
        if (RegWrite && (write_reg != {ADDR_WIDTH{1'b0}})) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Register array: async clear dominates, otherwise single-port write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (write_en_s) begin
            regs_r[write_reg] <= write_data;
        end
    end

    // Read port 1: combinational, address 0 forced to zero on the read path
    // as well so R0 reads zero regardless of array contents.
    always_comb begin
        read_data1 = {DATA_WIDTH{1'b0}};
        if (read_reg1 != {ADDR_WIDTH{1'b0}}) begin
            read_data1 = regs_r[read_reg1];
        end else begin
            read_data1 = {DATA_WIDTH{1'b0}};
        end
    end

    // Read port 2: identical and independent of port 1; no write bypass.
    always_comb begin
        read_data2 = {DATA_WIDTH{1'b0}};
        if (read_reg2 != {ADDR_WIDTH{1'b0}}) begin
            read_data2 = regs_r[read_reg2];
        end else begin
            read_data2 = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench for register_file. A reference array models the
//   architectural contents; each read drive pushes the expected pair onto a
//   scoreboard queue, and the owning test pops and compares after the
//   combinational outputs settle.
// -----------------------------------------------------------------------------
module tb_register_file;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    logic [31:0] mdl [32];
    exp_t        sb [$];
    int          n_cmp;
    int          n_fail;

    register_file #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive read addresses and push the expected pair from the model.
    task automatic drive_read(input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        read_reg1 = a1;
        read_reg2 = a2;
        e.d1 = (a1 == 5'd0) ? 32'h0000_0000 : mdl[a1];
        e.d2 = (a2 == 5'd0) ? 32'h0000_0000 : mdl[a2];
        sb.push_back(e);
    endtask

    // One write cycle; the model follows the architectural write rule.
    task automatic do_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWrite   = en;
        write_reg  = a;
        write_data = d;
        @(posedge clk);
        if (reset && en && (a != 5'd0)) mdl[a] = d;
        #1;
        RegWrite = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0000_0000;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0;
        clear_model();
        #10;
        for (int a = 0; a < 32; a++) begin
            drive_read(5'(a), 5'(31 - a));
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL reset_read a=%0d: got %h/%h expected %h/%h",
                         a, read_data1, read_data2, e.d1, e.d2);
            end
        end
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e;
        do_write(1'b1, 5'd5, 32'hA5A5_A5A5);
        drive_read(5'd5, 5'd0);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (read_data1 !== e.d1 || read_data2 !== e.d2 || e.d1 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL basic_rw: got %h/%h expected %h/%h",
                     read_data1, read_data2, 32'hA5A5_A5A5, 32'h0);
        end
    endtask

    task automatic test_second_reg();
        exp_t e;
        logic [4:0] a1 [2];
        a1[0] = 5'd12;
        a1[1] = 5'd5;
        do_write(1'b1, 5'd12, 32'hAAAA_AAAA);
        for (int k = 0; k < 2; k++) begin
            drive_read(a1[k], 5'd0);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL second_reg a=%0d: got %h/%h expected %h/%h",
                         a1[k], read_data1, read_data2, e.d1, e.d2);
            end
        end
    endtask

    task automatic test_r0_protect();
        exp_t e;
        do_write(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive_read(5'd0, 5'd5);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (read_data1 !== e.d1 || read_data2 !== e.d2 || e.d2 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL r0_protect: got %h/%h expected %h/%h",
                     read_data1, read_data2, 32'h0, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_top_and_unwritten();
        exp_t e;
        logic [4:0] a1 [3];
        logic [4:0] a2 [3];
        a1[0] = 5'd31; a2[0] = 5'd12;
        a1[1] = 5'd1;  a2[1] = 5'd2;
        a1[2] = 5'd30; a2[2] = 5'd31;
        do_write(1'b1, 5'd31, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            drive_read(a1[k], a2[k]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL top_unwritten %0d/%0d: got %h/%h expected %h/%h",
                         a1[k], a2[k], read_data1, read_data2, e.d1, e.d2);
            end
        end
    endtask

    task automatic test_enable_low();
        exp_t e;
        do_write(1'b0, 5'd5, 32'hDEAD_BEEF);
        drive_read(5'd5, 5'd5);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (read_data1 !== e.d1 || read_data2 !== e.d2 || e.d1 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL enable_low: got %h/%h expected %h/%h",
                     read_data1, read_data2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        @(negedge clk);
        RegWrite   = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'h5A5A_5A5A;
        drive_read(5'd5, 5'd5);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (read_data1 !== e.d1 || read_data2 !== e.d2 || e.d1 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL same_cycle_before: got %h/%h expected old %h",
                     read_data1, read_data2, 32'hA5A5_A5A5);
        end
        @(posedge clk);
        mdl[5] = 32'h5A5A_5A5A;
        #1;
        RegWrite = 1'b0;
        drive_read(5'd5, 5'd5);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (read_data1 !== e.d1 || read_data2 !== e.d2 || e.d1 !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL same_cycle_after: got %h/%h expected new %h",
                     read_data1, read_data2, 32'h5A5A_5A5A);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [4:0] a1 [5];
        logic [4:0] a2 [5];
        a1[0] = 5'd5;  a2[0] = 5'd12;
        a1[1] = 5'd31; a2[1] = 5'd5;
        a1[2] = 5'd3;  a2[2] = 5'd12;
        a1[3] = 5'd3;  a2[3] = 5'd31;
        a1[4] = 5'd3;  a2[4] = 5'd12;
        // Assert reset between edges; both reads land before the next rise.
        @(negedge clk);
        #1 reset = 1'b0;
        clear_model();
        for (int k = 0; k < 2; k++) begin
            drive_read(a1[k], a2[k]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL mid_reset_clear %0d/%0d: got %h/%h expected %h/%h",
                         a1[k], a2[k], read_data1, read_data2, e.d1, e.d2);
            end
        end
        // A write issued while reset is held must be discarded.
        do_write(1'b1, 5'd3, 32'h1111_1111);
        @(negedge clk);
        #1 reset = 1'b1;
        drive_read(a1[2], a2[2]);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
            n_fail++;
            $display("FAIL write_during_reset: got %h/%h expected %h/%h",
                     read_data1, read_data2, e.d1, e.d2);
        end
        // Storage works again after release.
        do_write(1'b1, 5'd3, 32'h3333_3333);
        for (int k = 3; k < 5; k++) begin
            drive_read(a1[k], a2[k]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL post_reset_write %0d/%0d: got %h/%h expected %h/%h",
                         a1[k], a2[k], read_data1, read_data2, e.d1, e.d2);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] v;
        for (int a = 1; a < 32; a++) begin
            v = $urandom;
            do_write(1'b1, 5'(a), v);
        end
        for (int a = 0; a < 32; a++) begin
            drive_read(5'(a), 5'((a * 7) % 32));
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (read_data1 !== e.d1 || read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL back_to_back a=%0d: got %h/%h expected %h/%h",
                         a, read_data1, read_data2, e.d1, e.d2);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        RegWrite   = 1'b0;
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        write_reg  = 5'd0;
        write_data = 32'h0000_0000;
        clear_model();

        test_reset();
        test_basic();
        test_second_reg();
        test_r0_protect();
        test_top_and_unwritten();
        test_enable_low();
        test_same_cycle();
        test_mid_reset();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose integer register file for the 32-bit processor datapath: 32 registers of 32 bits each.
- Two asynchronous (combinational) read ports feed the ALU operands.
- One synchronous write port is driven by the writeback stage.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH = 32 entries.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); clears all registers.
- RegWrite  input  1  write enable; sampled on rising clk.
- read_reg1  input  ADDR_WIDTH  address for read port 1.
- read_reg2  input  ADDR_WIDTH  address for read port 2.
- write_reg  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  write data.
- read_data1  output  DATA_WIDTH  contents of register read_reg1.
- read_data2  output  DATA_WIDTH  contents of register read_reg2.

Behaviour:
- Storage: 32 x DATA_WIDTH registers, R0..R31.
- Reset:
  - While reset == 0, all 32 registers are cleared to 0 immediately, without waiting for clk.
  - Reads during reset therefore return 0 on both ports.
  - Reset dominates any write: a write coinciding with, or issued during, reset is discarded.
- Write:
  - On rising clk, with reset == 1 and RegWrite == 1 and write_reg != 0, register[write_reg] <= write_data.
  - Result is visible on the read ports after the edge (1-cycle write latency).
  - RegWrite == 0 leaves all registers unchanged regardless of write_reg/write_data.
- R0 rule:
  - Writes to address 0 are ignored; R0 always reads 0x00000000 on both ports.
  - This is enforced on the read path as well as the write path, so R0 reads 0 under all conditions.
- Read:
  - Purely combinational: read_dataN = register[read_regN], or 0 when read_regN == 0.
  - Output changes within the same cycle the address changes; no clock involvement.
  - Both ports are independent: both may address the same register, including the one being written.
- Same-cycle read/write:
  - No write-through bypass.
  - Before the rising edge, a read of write_reg returns the old value.
  - After the edge, it returns write_data.
- Unwritten registers read 0 after reset.
- Reset mid-operation clears all previously written data; subsequent reads return 0 until rewritten.
- X/Z on inputs is outside the functional spec; no internal state beyond the register array.

Test Plan:
- Reset: hold reset=0 for 10 time units; read all addresses 0..31 -> read_data1 and read_data2 all 0x00000000. Release reset=1.
- Basic write/read:
  - RegWrite=1, write_reg=5, write_data=0xA5A5A5A5, one rising edge.
  - Then RegWrite=0, read_reg1=5, read_reg2=0 -> read_data1=0xA5A5A5A5, read_data2=0x00000000.
- Second register:
  - Write R12=0xAAAAAAAA.
  - Read read_reg1=12, read_reg2=0 -> 0xAAAAAAAA / 0x00000000.
  - Re-read R5 -> still 0xA5A5A5A5.
- R0 protection:
  - RegWrite=1, write_reg=0, write_data=0xFFFFFFFF, edge.
  - Read read_reg1=0, read_reg2=5 -> 0x00000000 / 0xA5A5A5A5.
- Top address and unwritten entries:
  - Write R31=0x12345678.
  - Read 31 and 12 -> 0x12345678 / 0xAAAAAAAA.
  - Read 1 and 2 -> 0x00000000 / 0x00000000.
- Enable and reset boundaries:
  - RegWrite=0 with write_reg=5, write_data=0xDEADBEEF, edge -> R5 still 0xA5A5A5A5.
  - Same-cycle read of write target before the edge returns old value; after the edge returns new value.
  - Assert reset=0 between clock edges -> all reads 0 immediately, before the next rising edge.
